// File: rtl/clock_divider_pkg.sv
// clock_divider_pkg: shared channel state encoding and divisor floor for clock_divider.
package clock_divider_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} ch_state_e;
  localparam int MIN_DIV = 2;
endpackage

// File: rtl/clock_divider_ch.sv
// clock_divider_ch: one divided-clock channel (FSM, counter, divisor, pending divisor).
// Ports: clk, rst_n (async active-low), en (run enable), wr (accepted divisor write),
//   wr_div (raw divisor), pend (pending divisor held), out_clk (registered divided clock),
//   tick (period-start pulse, only with CLOCK_DIVIDER_TICK_EN).
module clock_divider_ch
  import clock_divider_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
`ifdef CLOCK_DIVIDER_TICK_EN
  output logic             tick,
`endif
  output logic             pend,
  output logic             out_clk
);
  ch_state_e state, state_nx;
  logic [CNT_W-1:0] cnt, div, pend_div, cnt_nx, div_nx;
  logic [CNT_W:0] half;
  logic wrap, apply, out_nx;
  assign wrap = state != IDLE && cnt == div - 1'b1;
  // a pending divisor only lands on a period boundary (or while idle) so no pulse is cut short
  assign apply = pend && (state == IDLE || wrap);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // RUN dropping enable exactly at wrap has already completed its period, so it goes straight to IDLE
  always_comb
    state_nx = state == IDLE ? (en ? RUN : IDLE) :
               state == RUN  ? (en ? RUN : (wrap ? IDLE : STOPPING)) :
               wrap          ? (en ? RUN : IDLE) : STOPPING;
  // out_clk is registered, so it is computed from the next counter and next divisor
  always_comb begin
    cnt_nx = (state == IDLE || wrap) ? '0 : cnt + 1'b1;
    div_nx = apply ? pend_div : div;
    half = ({1'b0, div_nx} + 1'b1) >> 1;
    out_nx = state_nx != IDLE && {1'b0, cnt_nx} < half;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      div <= CNT_W'(DEFAULT_DIV);
      pend <= 1'b0;
      pend_div <= CNT_W'(DEFAULT_DIV);
      out_clk <= 1'b0;
    end else begin
      cnt <= cnt_nx;
      div <= div_nx;
      pend <= wr || (pend && !apply);
      pend_div <= wr ? (wr_div < CNT_W'(MIN_DIV) ? CNT_W'(MIN_DIV) : wr_div) : pend_div;
      out_clk <= out_nx;
    end
`ifdef CLOCK_DIVIDER_TICK_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tick <= 1'b0;
    else tick <= state_nx != IDLE && cnt_nx == '0;
`endif
endmodule

// File: rtl/clock_divider.sv
// clock_divider: NUM_CH independent glitch-free programmable clock dividers.
// Ports: clk, rst_n (async active-low), ch_en (per-channel run), cfg_valid/cfg_ready/cfg_ch/cfg_div
//   (divisor update handshake), out_clk (divided clocks), tick (period-start pulses).
// Macro CLOCK_DIVIDER_TICK_EN adds the tick port and its logic.
module clock_divider
  import clock_divider_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 8,
  parameter int DEFAULT_DIV = 4,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
`ifdef CLOCK_DIVIDER_TICK_EN
  output logic [NUM_CH-1:0] tick,
`endif
  output logic [NUM_CH-1:0] out_clk
);
  localparam int CH_N = 2 ** CH_W;
  logic [NUM_CH-1:0] pend;
  logic [CH_N-1:0] pend_ext;
  // unused channel addresses read as not-pending, so writes to them are accepted and dropped
  assign pend_ext = CH_N'(pend);
  assign cfg_ready = !pend_ext[cfg_ch];
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clock_divider_ch #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .en(ch_en[i]),
      .wr(cfg_valid && cfg_ready && cfg_ch == CH_W'(i)),
      .wr_div(cfg_div),
`ifdef CLOCK_DIVIDER_TICK_EN
      .tick(tick[i]),
`endif
      .pend(pend[i]),
      .out_clk(out_clk[i])
    );
  end
endmodule

// File: tb/tb_clock_divider.sv
// tb_clock_divider: directed table-driven and sequence checks of clock_divider.
module tb_clock_divider;
  logic clk = 0, rst_n = 1;
  logic [3:0] ch_en = '0, out_clk;
  logic cfg_valid = 0, cfg_ready;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_div = '0;
  logic [4:0] en5 = '0, o5;
  logic v5 = 0, r5;
  logic [2:0] ch5 = '0;
  logic [7:0] d5 = '0;
`ifdef CLOCK_DIVIDER_TICK_EN
  logic [3:0] tick;
  logic [4:0] tick5;
`endif
  int errs = 0, checks = 0;

  clock_divider dut (
    .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div),
`ifdef CLOCK_DIVIDER_TICK_EN
    .tick(tick),
`endif
    .out_clk(out_clk));

  clock_divider #(.NUM_CH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .ch_en(en5), .cfg_valid(v5), .cfg_ready(r5),
    .cfg_ch(ch5), .cfg_div(d5),
`ifdef CLOCK_DIVIDER_TICK_EN
    .tick(tick5),
`endif
    .out_clk(o5));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic pre_rst;
    logic [3:0] en;
    logic v;
    logic [1:0] c;
    logic [7:0] d;
    logic [3:0] out;
    logic rdy;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] e, input logic v, input logic [1:0] c, input logic [7:0] d);
    ch_en = e; cfg_valid = v; cfg_ch = c; cfg_div = d;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    ch_en = '0; cfg_valid = 0; rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  initial begin
    // ch0 at default divisor 4
    tbl.push_back('{1, 4'b0001, 0, 0, 0, 4'b0001, 1});
    tbl.push_back('{0, 4'b0001, 0, 0, 0, 4'b0001, 1});
    tbl.push_back('{0, 4'b0001, 0, 0, 0, 4'b0000, 1});
    tbl.push_back('{0, 4'b0001, 0, 0, 0, 4'b0000, 1});
    tbl.push_back('{0, 4'b0001, 0, 0, 0, 4'b0001, 1});
    tbl.push_back('{0, 4'b0001, 0, 0, 0, 4'b0001, 1});
    tbl.push_back('{0, 4'b0001, 0, 0, 0, 4'b0000, 1});
    tbl.push_back('{0, 4'b0001, 0, 0, 0, 4'b0000, 1});
    // ch1: write 5 mid-period, second write 9 ignored, then write 2 on the wrap cycle
    tbl.push_back('{1, 4'b0010, 0, 1, 0, 4'b0010, 1});
    tbl.push_back('{0, 4'b0010, 1, 1, 5, 4'b0010, 0});
    tbl.push_back('{0, 4'b0010, 1, 1, 9, 4'b0000, 0});
    tbl.push_back('{0, 4'b0010, 0, 1, 0, 4'b0000, 0});
    tbl.push_back('{0, 4'b0010, 0, 1, 0, 4'b0010, 1});
    tbl.push_back('{0, 4'b0010, 0, 1, 0, 4'b0010, 1});
    tbl.push_back('{0, 4'b0010, 0, 1, 0, 4'b0010, 1});
    tbl.push_back('{0, 4'b0010, 0, 1, 0, 4'b0000, 1});
    tbl.push_back('{0, 4'b0010, 0, 1, 0, 4'b0000, 1});
    tbl.push_back('{0, 4'b0010, 0, 1, 0, 4'b0010, 1});
    tbl.push_back('{0, 4'b0010, 0, 1, 0, 4'b0010, 1});
    tbl.push_back('{0, 4'b0010, 0, 1, 0, 4'b0010, 1});
    tbl.push_back('{0, 4'b0010, 0, 1, 0, 4'b0000, 1});
    tbl.push_back('{0, 4'b0010, 0, 1, 0, 4'b0000, 1});
    tbl.push_back('{0, 4'b0010, 1, 1, 2, 4'b0010, 0});
    tbl.push_back('{0, 4'b0010, 0, 1, 0, 4'b0010, 0});
    tbl.push_back('{0, 4'b0010, 0, 1, 0, 4'b0010, 0});
    tbl.push_back('{0, 4'b0010, 0, 1, 0, 4'b0000, 0});
    tbl.push_back('{0, 4'b0010, 0, 1, 0, 4'b0000, 0});
    tbl.push_back('{0, 4'b0010, 0, 1, 0, 4'b0010, 1});
    tbl.push_back('{0, 4'b0010, 0, 1, 0, 4'b0000, 1});
    tbl.push_back('{0, 4'b0010, 0, 1, 0, 4'b0010, 1});
    tbl.push_back('{0, 4'b0010, 0, 1, 0, 4'b0000, 1});

    #1 rst_n = 0;
    #1;
    chk("reset_out", 32'(out_clk), 0);
    chk("reset_ready", 32'(cfg_ready), 1);
    chk("reset_out5", 32'(o5), 0);
`ifdef CLOCK_DIVIDER_TICK_EN
    chk("reset_tick", 32'(tick), 0);
`endif
    @(posedge clk); #1;
    chk("reset_hold_out", 32'(out_clk), 0);
    rst_n = 1;

    foreach (tbl[i]) begin
      if (tbl[i].pre_rst) do_reset();
      cyc(tbl[i].en, tbl[i].v, tbl[i].c, tbl[i].d);
      chk($sformatf("vec%0d_out", i), 32'(out_clk), 32'(tbl[i].out));
      chk($sformatf("vec%0d_ready", i), 32'(cfg_ready), 32'(tbl[i].rdy));
    end

    // ch2: D=6 loaded while idle, enable dropped at counter 1, then re-enabled
    do_reset();
    cyc(4'b0000, 1, 2, 6);
    chk("ch2_pend_ready", 32'(cfg_ready), 0);
    cyc(4'b0000, 0, 2, 0);
    chk("ch2_applied_ready", 32'(cfg_ready), 1);
    chk("ch2_idle_out", 32'(out_clk), 0);
    cyc(4'b0100, 0, 2, 0);
    chk("ch2_cnt0", 32'(out_clk), 32'h4);
    cyc(4'b0100, 0, 2, 0);
    chk("ch2_cnt1", 32'(out_clk), 32'h4);
    begin
      logic [3:0] stop_exp[7] = '{4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      for (int k = 0; k < 7; k++) begin
        cyc(4'b0000, 0, 2, 0);
        chk($sformatf("ch2_stop%0d", k), 32'(out_clk), 32'(stop_exp[k]));
      end
    end
    cyc(4'b0100, 0, 2, 0);
    chk("ch2_restart", 32'(out_clk), 32'h4);

    // ch3: divisor 0 clamps to 2
    cyc(4'b0000, 1, 3, 0);
    cyc(4'b0000, 0, 3, 0);
    chk("ch3_ready", 32'(cfg_ready), 1);
    for (int k = 0; k < 4; k++) begin
      cyc(4'b1000, 0, 3, 0);
      chk($sformatf("ch3_d2_%0d", k), 32'(out_clk), k % 2 == 0 ? 32'h8 : 32'h0);
`ifdef CLOCK_DIVIDER_TICK_EN
      chk($sformatf("ch3_tick_%0d", k), 32'(tick), k % 2 == 0 ? 32'h8 : 32'h0);
`endif
    end

    // reset mid-period with a pending write outstanding
    cyc(4'b1111, 1, 1, 7);
    chk("rst_pre_out0", 32'(out_clk), 32'hf);
    cyc(4'b1111, 0, 1, 0);
    chk("rst_pre_out1", 32'(out_clk), 32'h7);
    chk("rst_pre_ready", 32'(cfg_ready), 0);
    #2 rst_n = 0;
    #1;
    chk("rst_async_out", 32'(out_clk), 0);
    chk("rst_async_ready", 32'(cfg_ready), 1);
`ifdef CLOCK_DIVIDER_TICK_EN
    chk("rst_async_tick", 32'(tick), 0);
`endif
    @(posedge clk); #1;
    rst_n = 1;
    begin
      logic [3:0] post_exp[5] = '{4'hf, 4'hf, 4'h0, 4'h0, 4'hf};
      for (int k = 0; k < 5; k++) begin
        cyc(4'b1111, 0, 1, 0);
        chk($sformatf("rst_post%0d", k), 32'(out_clk), 32'(post_exp[k]));
      end
    end

    // out-of-range channel write on the 5-channel instance
    en5 = 5'b11111; v5 = 1; ch5 = 3'd7; d5 = 8'd0;
    #1;
    chk("oor_ready", 32'(r5), 1);
    @(posedge clk); #1;
    v5 = 0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      chk($sformatf("oor_out%0d", k), 32'(o5), (k % 4) < 2 ? 32'h1f : 32'h0);
    end
    for (int c = 0; c < 5; c++) begin
      ch5 = 3'(c);
      #1;
      chk($sformatf("oor_ready_ch%0d", c), 32'(r5), 1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
